// File: rtl/timer8254_pkg.sv
// Shared definitions for the 8254 timer read path.
package timer8254_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned COUNT_W = 16;

    // RW field of the control word.
    typedef enum logic [1:0] {
        RW_LATCH   = 2'b00,
        RW_LSB     = 2'b01,
        RW_MSB     = 2'b10,
        RW_LSB_MSB = 2'b11
    } rw_e;

    // Bit positions within the status byte {out, null_count, rw[1:0], mode[2:0], bcd}.
    localparam int unsigned ST_BCD_BIT    = 0;
    localparam int unsigned ST_MODE_LSB   = 1;
    localparam int unsigned ST_MODE_MSB   = 3;
    localparam int unsigned ST_RW_LSB     = 4;
    localparam int unsigned ST_RW_MSB     = 5;
    localparam int unsigned ST_NULL_BIT   = 6;
    localparam int unsigned ST_OUT_BIT    = 7;

endpackage : timer8254_pkg

// File: rtl/read_byte_sequencer.sv
// Tracks the RW mode and the LSB/MSB pointer; decides which byte each count read returns.
module read_byte_sequencer
    import timer8254_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_wr_i,
    input  logic [1:0] mode_rw_i,
    input  logic       count_rd_i,
    output logic       msb_next_o,
    output logic       sel_msb_c,
    output logic       seq_end_c
);

    rw_e  rw_q, rw_d;
    logic msb_q, msb_d;

    // Mode and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q  <= RW_LSB_MSB;
            msb_q <= 1'b0;
        end else begin
            rw_q  <= rw_d;
            msb_q <= msb_d;
        end
    end

    // A mode write restarts the byte order; count reads toggle the pointer only in LSB+MSB mode.
    always_comb begin
        rw_d  = rw_q;
        msb_d = msb_q;
        if (mode_wr_i) begin
            rw_d  = rw_e'(mode_rw_i);
            msb_d = 1'b0;
        end else if (count_rd_i && (rw_q == RW_LSB_MSB)) begin
            msb_d = ~msb_q;
        end
    end

    // Byte select for the current read and whether it completes a latched sequence.
    always_comb begin
        sel_msb_c = (rw_q == RW_MSB) || ((rw_q == RW_LSB_MSB) && msb_q);
        seq_end_c = (rw_q != RW_LSB_MSB) || msb_q;
    end

    assign msb_next_o = msb_q;

endmodule : read_byte_sequencer

// File: rtl/counter_read_latch.sv
// Output latches, status latch and read data register for one 8254 counter.
module counter_read_latch
    import timer8254_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_DATA = 8'h00,
    parameter bit                STATUS_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] ce_count_high,
    input  logic [DATA_W-1:0] ce_count_low,
    input  logic [DATA_W-1:0] status_in,
    input  logic              cw_write,
    input  logic [1:0]        cw_rw,
    input  logic              rb_strobe,
    input  logic              rb_count_n,
    input  logic              rb_status_n,
    input  logic              rd_strobe,
    output logic [DATA_W-1:0] data_out,
    output logic              count_latched,
    output logic              status_latched,
    output logic              msb_next
);

    logic [COUNT_W-1:0] ol_q, ol_d;
    logic [DATA_W-1:0]  st_q, st_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               cl_q, cl_d;
    logic               sl_q, sl_d;

    logic               mode_wr_c;
    logic               latch_req_c;
    logic               status_req_c;
    logic               rd_acc_c;
    logic               count_rd_c;
    logic               sel_msb_c;
    logic               seq_end_c;
    logic [COUNT_W-1:0] src_c;

    // Command decode with cw_write > rb_strobe > rd_strobe priority.
    always_comb begin
        mode_wr_c    = cw_write && (cw_rw != RW_LATCH);
        latch_req_c  = (cw_write && (cw_rw == RW_LATCH)) ||
                       (!cw_write && rb_strobe && !rb_count_n);
        status_req_c = STATUS_EN && !cw_write && rb_strobe && !rb_status_n;
        rd_acc_c     = rd_strobe && !cw_write && !rb_strobe;
        count_rd_c   = rd_acc_c && !sl_q;
    end

    read_byte_sequencer u_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode_wr_i  (mode_wr_c),
        .mode_rw_i  (cw_rw),
        .count_rd_i (count_rd_c),
        .msb_next_o (msb_next),
        .sel_msb_c  (sel_msb_c),
        .seq_end_c  (seq_end_c)
    );

    // Latch, status and read-data next state.
    always_comb begin
        ol_d   = ol_q;
        st_d   = st_q;
        data_d = data_q;
        cl_d   = cl_q;
        sl_d   = sl_q;
        src_c  = cl_q ? ol_q : {ce_count_high, ce_count_low};

        if (mode_wr_c) begin
            cl_d = 1'b0;
            sl_d = 1'b0;
        end

        // First latch wins until the latched value has been fully read.
        if (latch_req_c && !cl_q) begin
            ol_d = {ce_count_high, ce_count_low};
            cl_d = 1'b1;
        end

        if (status_req_c && !sl_q) begin
            st_d = status_in;
            sl_d = 1'b1;
        end

        // A pending status byte is returned ahead of any count byte.
        if (rd_acc_c) begin
            if (sl_q) begin
                data_d = st_q;
                sl_d   = 1'b0;
            end else begin
                data_d = sel_msb_c ? src_c[COUNT_W-1:DATA_W] : src_c[DATA_W-1:0];
                if (cl_q && seq_end_c) begin
                    cl_d = 1'b0;
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ol_q   <= '0;
            st_q   <= '0;
            data_q <= RESET_DATA;
            cl_q   <= 1'b0;
            sl_q   <= 1'b0;
        end else begin
            ol_q   <= ol_d;
            st_q   <= st_d;
            data_q <= data_d;
            cl_q   <= cl_d;
            sl_q   <= sl_d;
        end
    end

    assign data_out       = data_q;
    assign count_latched  = cl_q;
    assign status_latched = sl_q;

endmodule : counter_read_latch

// File: tb/tb_counter_read_latch.sv
// Directed and randomized checks of counter_read_latch against a behavioural model.
module tb_counter_read_latch;

    logic       clk;
    logic       rst_n;
    logic [7:0] ce_count_high;
    logic [7:0] ce_count_low;
    logic [7:0] status_in;
    logic       cw_write;
    logic [1:0] cw_rw;
    logic       rb_strobe;
    logic       rb_count_n;
    logic       rb_status_n;
    logic       rd_strobe;
    logic [7:0] data_out;
    logic       count_latched;
    logic       status_latched;
    logic       msb_next;

    int n_tests;
    int n_fail;

    // Reference state, expressed directly in terms of the read-path rules.
    int          m_mode;      // 1 = LSB, 2 = MSB, 3 = LSB then MSB
    bit          m_second;    // next LSB+MSB read returns the high byte
    bit          m_held;      // count frozen in the output latch
    int          m_hold_val;
    bit          m_st_held;
    int          m_st_val;
    int          m_data;

    counter_read_latch #(
        .RESET_DATA (8'h00),
        .STATUS_EN  (1'b1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ce_count_high  (ce_count_high),
        .ce_count_low   (ce_count_low),
        .status_in      (status_in),
        .cw_write       (cw_write),
        .cw_rw          (cw_rw),
        .rb_strobe      (rb_strobe),
        .rb_count_n     (rb_count_n),
        .rb_status_n    (rb_status_n),
        .rd_strobe      (rd_strobe),
        .data_out       (data_out),
        .count_latched  (count_latched),
        .status_latched (status_latched),
        .msb_next       (msb_next)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int live_count();
        return int'({ce_count_high, ce_count_low});
    endfunction

    task automatic model_reset();
        m_mode     = 3;
        m_second   = 1'b0;
        m_held     = 1'b0;
        m_hold_val = 0;
        m_st_held  = 1'b0;
        m_st_val   = 0;
        m_data     = 0;
    endtask

    // Apply one clock edge worth of commands to the model.
    task automatic model_edge(input bit w, input int rw, input bit rb, input bit rbc_n,
                              input bit rbs_n, input bit rd, input int live, input int st);
        int  v;
        bit  done;
        if (w) begin
            if (rw != 0) begin
                m_mode    = rw;
                m_second  = 1'b0;
                m_held    = 1'b0;
                m_st_held = 1'b0;
            end else if (!m_held) begin
                m_hold_val = live;
                m_held     = 1'b1;
            end
        end else if (rb) begin
            if (!rbc_n && !m_held) begin
                m_hold_val = live;
                m_held     = 1'b1;
            end
            if (!rbs_n && !m_st_held) begin
                m_st_val  = st;
                m_st_held = 1'b1;
            end
        end else if (rd) begin
            if (m_st_held) begin
                m_data    = m_st_val;
                m_st_held = 1'b0;
            end else begin
                v    = m_held ? m_hold_val : live;
                done = 1'b1;
                if (m_mode == 1) begin
                    m_data = v % 256;
                end else if (m_mode == 2) begin
                    m_data = v / 256;
                end else if (!m_second) begin
                    m_data   = v % 256;
                    m_second = 1'b1;
                    done     = 1'b0;
                end else begin
                    m_data   = v / 256;
                    m_second = 1'b0;
                end
                if (done) m_held = 1'b0;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".data_out"},       16'(data_out),       16'(m_data));
        check({tag, ".count_latched"},  16'(count_latched),  16'(m_held));
        check({tag, ".status_latched"}, 16'(status_latched), 16'(m_st_held));
        check({tag, ".msb_next"},       16'(msb_next),       16'(m_second));
    endtask

    // One clock cycle with the given strobes, then model update and comparison.
    task automatic cyc(input string tag, input bit w, input logic [1:0] rw, input bit rb,
                       input bit rbc_n, input bit rbs_n, input bit rd);
        int live, st;
        cw_write    = w;
        cw_rw       = rw;
        rb_strobe   = rb;
        rb_count_n  = rbc_n;
        rb_status_n = rbs_n;
        rd_strobe   = rd;
        live        = live_count();
        st          = int'(status_in);
        @(posedge clk);
        model_edge(w, int'(rw), rb, rbc_n, rbs_n, rd, live, st);
        #1;
        compare_all(tag);
        cw_write    = 1'b0;
        rb_strobe   = 1'b0;
        rb_count_n  = 1'b1;
        rb_status_n = 1'b1;
        rd_strobe   = 1'b0;
    endtask

    task automatic rd(input string tag);
        cyc(tag, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic set_live(input logic [15:0] v);
        {ce_count_high, ce_count_low} = v;
    endtask

    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst_n       = 1'b1;
        cw_write    = 1'b0;
        cw_rw       = 2'b00;
        rb_strobe   = 1'b0;
        rb_count_n  = 1'b1;
        rb_status_n = 1'b1;
        rd_strobe   = 1'b0;
        status_in   = 8'h00;
        set_live(16'h0000);
        model_reset();
        #2;
        apply_reset("reset");
        check("reset.data_out_const", 16'(data_out), 16'h0000);

        // LSB+MSB of a live count.
        cyc("t1.mode", 1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
        set_live(16'h1234);
        rd("t1.rd0");
        check("t1.lsb", 16'(data_out), 16'h0034);
        check("t1.msb_next1", 16'(msb_next), 16'h0001);
        rd("t1.rd1");
        check("t1.msb", 16'(data_out), 16'h0012);
        check("t1.msb_next0", 16'(msb_next), 16'h0000);

        // Second latch ignored while the first is pending.
        set_live(16'hABCD);
        cyc("t2.latch0", 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        set_live(16'hABC0);
        cyc("t2.idle", 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        set_live(16'hAB00);
        cyc("t2.latch1", 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        rd("t2.rd0");
        check("t2.lsb", 16'(data_out), 16'h00CD);
        rd("t2.rd1");
        check("t2.msb", 16'(data_out), 16'h00AB);
        check("t2.cl_clear", 16'(count_latched), 16'h0000);
        rd("t2.rd2");
        check("t2.live_lsb", 16'(data_out), 16'h0000);

        // Single-byte modes.
        cyc("t3.mode_lsb", 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0);
        set_live(16'h00FF);
        cyc("t3.latch", 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        set_live(16'h0010);
        rd("t3.rd");
        check("t3.lsb", 16'(data_out), 16'h00FF);
        check("t3.cl_clear", 16'(count_latched), 16'h0000);
        cyc("t3.mode_msb", 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
        set_live(16'h5A00);
        rd("t3.rd_msb");
        check("t3.msb", 16'(data_out), 16'h005A);

        // Read-back of count and status.
        cyc("t4.mode", 1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
        set_live(16'h0102);
        status_in = 8'hB6;
        cyc("t4.rb", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        set_live(16'h00FE);
        status_in = 8'h00;
        rd("t4.rd0");
        check("t4.status", 16'(data_out), 16'h00B6);
        rd("t4.rd1");
        check("t4.lsb", 16'(data_out), 16'h0002);
        rd("t4.rd2");
        check("t4.msb", 16'(data_out), 16'h0001);

        // Read coinciding with a mode write is dropped.
        set_live(16'h4321);
        cyc("t5.latch", 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        rd("t5.rd0");
        cyc("t5.collide", 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1);
        check("t5.hold", 16'(data_out), 16'h0021);
        check("t5.msb_next", 16'(msb_next), 16'h0000);
        check("t5.cl", 16'(count_latched), 16'h0000);

        // Reset between the bytes of a latched pair.
        cyc("t6.mode", 1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
        set_live(16'h7788);
        cyc("t6.latch", 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        rd("t6.rd0");
        apply_reset("t6.reset");
        check("t6.cl_reset", 16'(count_latched), 16'h0000);
        set_live(16'h9911);
        rd("t6.rd1");
        check("t6.live_lsb", 16'(data_out), 16'h0011);

        // Randomized traffic with coincident strobes.
        for (int i = 0; i < 400; i++) begin
            bit         w, rb, rbc_n, rbs_n, r;
            logic [1:0] rw;
            w     = ($urandom_range(0, 9) == 0);
            rb    = ($urandom_range(0, 6) == 0);
            r     = ($urandom_range(0, 2) == 0);
            rw    = 2'($urandom_range(0, 3));
            rbc_n = 1'($urandom_range(0, 1));
            rbs_n = 1'($urandom_range(0, 1));
            status_in = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) set_live(16'($urandom_range(0, 65535)));
            else if ($urandom_range(0, 1) == 1) set_live(16'(live_count() - 1));
            cyc("rand", w, rw, rb, rbc_n, rbs_n, r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_counter_read_latch
